register_window_file: RTL and testbench
=======================================

// Module: register_window_file
// PURPOSE
//  - Parametrised successor to the flat 8-entry register_block_32bit: a SPARC-style windowed integer register file.
//  - Contains 8 globals plus NWINDOWS overlapping windows of 8 outs and 8 locals each.
//  - Save/Restore move the current window pointer (CWP), with window-invalid-mask (WIM) overflow/underflow trap detection.
//  - Two asynchronous read ports (A, B) and one synchronous write port; feeds the ALU operand latches in the datapath.
// PARAMETERS
//  WIDTH     32  data width of every register
//  NWINDOWS  4   number of register windows, 2..32
//  CWP_W     2   CWP width = $clog2(NWINDOWS); derived, do not override
// PORTS
//  Clk      in   1         clock, rising edge
//  Rst_n    in   1         asynchronous reset, active low
//  RA       in   5         architectural read address, port A (r0..r31)
//  RB       in   5         architectural read address, port B
//  Aout     out  WIDTH     port A read data, combinational
//  Bout     out  WIDTH     port B read data, combinational
//  RD       in   5         write address
//  in       in   WIDTH     write data
//  WE       in   1         write enable
//  Save     in   1         request CWP <= CWP-1 (mod NWINDOWS)
//  Restore  in   1         request CWP <= CWP+1 (mod NWINDOWS)
//  CWP_WE   in   1         direct CWP load, trap/return path
//  CWP_in   in   CWP_W     value for direct CWP load
//  WIM_WE   in   1         WIM load enable
//  WIM_in   in   NWINDOWS  value for WIM load
//  CWP      out  CWP_W     current window pointer
//  WIM      out  NWINDOWS  window invalid mask
//  Ovf_trap out  1         one-cycle pulse: Save refused
//  Unf_trap out  1         one-cycle pulse: Restore refused
//  Err      out  1         one-cycle pulse: Save and Restore asserted together
// BEHAVIOUR
//  Reset (async, Rst_n=0)
//  - All physical registers = 0, CWP = 0, WIM = 0.
//  - Ovf_trap, Unf_trap and Err = 0.
//  Physical map (P = 8 + 16*NWINDOWS entries)
//  - r0..r7   -> phys[r].
//  - r8..r15  -> phys[8 + 16*CWP + (r-8)]            (outs).
//  - r16..r23 -> phys[8 + 16*CWP + 8 + (r-16)]       (locals).
//  - r24..r31 -> phys[8 + 16*((CWP+1)%NWINDOWS) + (r-24)], so ins alias the outs of window CWP+1.
//  Reads
//  - r0 reads 0.
//  - Otherwise combinational from the map using the current CWP.
//  - A read at the same address as a same-cycle write returns the old value; there is no bypass.
//  Writes
//  - On a rising Clk with WE=1 and RD!=0, the mapped entry <= in.
//  - RD=0 is ignored.
//  - Mapping uses the pre-edge CWP, even when Save/Restore/CWP_WE update CWP on the same edge.
//  CWP update, per edge, in priority order
//  1. CWP_WE=1: CWP <= CWP_in if CWP_in < NWINDOWS, else unchanged. Save/Restore are ignored with no trap.
//  2. Save=1 and Restore=1: CWP unchanged, Err pulses next cycle.
//  3. Save=1: n = (CWP-1) mod NWINDOWS. If WIM[n] then CWP unchanged and Ovf_trap=1 for one cycle, else CWP <= n.
//  4. Restore=1: n = (CWP+1) mod NWINDOWS. If WIM[n] then CWP unchanged and Unf_trap=1 for one cycle, else CWP <= n.
//  - Wrap-around: Save at CWP=0 targets NWINDOWS-1; Restore at CWP=NWINDOWS-1 targets 0.
//  - Trap/Err outputs are registered: asserted the cycle after the request, cleared the following cycle unless re-requested.
//  WIM update
//  - WIM_WE=1: WIM <= WIM_in at the edge.
//  - A Save/Restore on the same edge checks the old WIM.
//  Reset mid-operation
//  - Asynchronous: the array, CWP, WIM and pulse outputs clear immediately.
//  - A write in flight is lost.
// STRUCTURE
//  - Shared package regfile_pkg: REG_ADDR_W=5, NGLOBALS=8, WIN_REGS=16; function phys_index(addr, cwp, nwin).
//  - Sub-module window_ctrl: CWP/WIM registers, priority logic, trap/Err pulses.
//  - The top holds the physical array, both read muxes and the write decode.
// TESTING
//  1. Reset, WE=1 RD=5 in=00001111, RA=5 -> Aout=00001111 next cycle; RD=0 write, RA=0 -> Aout=0.
//  2. CWP=0, write r8=AAAA0000, Save -> CWP=3 (NWINDOWS=4); RA=24 reads AAAA0000; Restore -> CWP=0, RA=8 reads AAAA0000.
//  3. Write r16=1234 at CWP=0, Save, write r16=5678, Restore -> RA=16 reads 1234; locals are not shared.
//  4. WIM=1000, CWP=0, Save -> Ovf_trap=1 one cycle, CWP stays 0; WIM=0010, Restore -> Unf_trap=1, CWP 0.
//  5. Save+Restore together -> Err=1 one cycle, CWP unchanged; CWP_WE=1 CWP_in=2 with Save -> CWP=2, no trap.
//  6. Drop Rst_n mid-sequence at CWP=2, WIM=0101 -> CWP=0, WIM=0, all reads 0, pulses 0 without a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the architectural-to-physical register mapping
// for the windowed register file.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NGLOBALS   = 8;
    localparam int WIN_REGS   = 16;

    // Ins (r24..r31) alias the outs of the next window up, giving the overlap.
    function automatic int phys_index(input logic [REG_ADDR_W-1:0] addr,
                                      input int cwp,
                                      input int nwin);
        int a;
        a = int'(addr);
        if (a < NGLOBALS)
            return a;
        else if (a < 24)
            return NGLOBALS + WIN_REGS * cwp + (a - 8);
        else
            return NGLOBALS + WIN_REGS * ((cwp + 1) % nwin) + (a - 24);
    endfunction

endpackage

// File: rtl/window_ctrl.sv
// Current window pointer and window invalid mask, with Save/Restore
// priority resolution and registered trap/error pulses.
module window_ctrl
    import regfile_pkg::*;
#(
    parameter  int NWINDOWS = 4,
    localparam int CWP_W    = $clog2(NWINDOWS)
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Save,
    input  logic                Restore,
    input  logic                CWP_WE,
    input  logic [CWP_W-1:0]    CWP_in,
    input  logic                WIM_WE,
    input  logic [NWINDOWS-1:0] WIM_in,
    output logic [CWP_W-1:0]    CWP,
    output logic [NWINDOWS-1:0] WIM,
    output logic                Ovf_trap,
    output logic                Unf_trap,
    output logic                Err
);

    logic [CWP_W-1:0] cwp_dec;
    logic [CWP_W-1:0] cwp_inc;
    logic [CWP_W-1:0] cwp_next;
    logic             ovf_next;
    logic             unf_next;
    logic             err_next;

    assign cwp_dec = (CWP == '0) ? CWP_W'(NWINDOWS - 1) : CWP - 1'b1;
    assign cwp_inc = (int'(CWP) == NWINDOWS - 1) ? '0 : CWP + 1'b1;

    // A direct load outranks everything; the trap checks use the pre-edge WIM.
    always_comb begin
        cwp_next = CWP;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        err_next = 1'b0;
        if (CWP_WE) begin
            if (int'(CWP_in) < NWINDOWS)
                cwp_next = CWP_in;
        end else if (Save && Restore) begin
            err_next = 1'b1;
        end else if (Save) begin
            if (WIM[cwp_dec])
                ovf_next = 1'b1;
            else
                cwp_next = cwp_dec;
        end else if (Restore) begin
            if (WIM[cwp_inc])
                unf_next = 1'b1;
            else
                cwp_next = cwp_inc;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            CWP      <= '0;
            WIM      <= '0;
            Ovf_trap <= 1'b0;
            Unf_trap <= 1'b0;
            Err      <= 1'b0;
        end else begin
            CWP      <= cwp_next;
            Ovf_trap <= ovf_next;
            Unf_trap <= unf_next;
            Err      <= err_next;
            if (WIM_WE)
                WIM <= WIM_in;
        end
    end

endmodule

// File: rtl/register_window_file.sv
// SPARC-style windowed integer register file: 8 globals plus NWINDOWS
// overlapping windows, two combinational read ports and one write port.
module register_window_file
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int NWINDOWS = 4,
    localparam int CWP_W    = $clog2(NWINDOWS)
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [REG_ADDR_W-1:0] RA,
    input  logic [REG_ADDR_W-1:0] RB,
    output logic [WIDTH-1:0]      Aout,
    output logic [WIDTH-1:0]      Bout,
    input  logic [REG_ADDR_W-1:0] RD,
    input  logic [WIDTH-1:0]      in,
    input  logic                  WE,
    input  logic                  Save,
    input  logic                  Restore,
    input  logic                  CWP_WE,
    input  logic [CWP_W-1:0]      CWP_in,
    input  logic                  WIM_WE,
    input  logic [NWINDOWS-1:0]   WIM_in,
    output logic [CWP_W-1:0]      CWP,
    output logic [NWINDOWS-1:0]   WIM,
    output logic                  Ovf_trap,
    output logic                  Unf_trap,
    output logic                  Err
);

    localparam int NPHYS = NGLOBALS + WIN_REGS * NWINDOWS;
    localparam int IDX_W = $clog2(NPHYS);

    logic [WIDTH-1:0] phys [NPHYS];
    logic [IDX_W-1:0] a_idx;
    logic [IDX_W-1:0] b_idx;
    logic [IDX_W-1:0] w_idx;

    window_ctrl #(.NWINDOWS(NWINDOWS)) u_window_ctrl (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Save     (Save),
        .Restore  (Restore),
        .CWP_WE   (CWP_WE),
        .CWP_in   (CWP_in),
        .WIM_WE   (WIM_WE),
        .WIM_in   (WIM_in),
        .CWP      (CWP),
        .WIM      (WIM),
        .Ovf_trap (Ovf_trap),
        .Unf_trap (Unf_trap),
        .Err      (Err)
    );

    // All three ports map through the pre-edge CWP.
    assign a_idx = IDX_W'(phys_index(RA, int'(CWP), NWINDOWS));
    assign b_idx = IDX_W'(phys_index(RB, int'(CWP), NWINDOWS));
    assign w_idx = IDX_W'(phys_index(RD, int'(CWP), NWINDOWS));

    assign Aout = (RA == '0) ? '0 : phys[a_idx];
    assign Bout = (RB == '0) ? '0 : phys[b_idx];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NPHYS; i++)
                phys[i] <= '0;
        end else if (WE && (RD != '0)) begin
            phys[w_idx] <= in;
        end
    end

endmodule

// File: tb/tb_register_window_file.sv
// Directed self-checking bench for register_window_file (NWINDOWS=4).
module tb_register_window_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra, rb, rd;
    logic [31:0] aout, bout, wdata;
    logic        we, save, restore, cwp_we, wim_we;
    logic [1:0]  cwp_in, cwp;
    logic [3:0]  wim_in, wim;
    logic        ovf, unf, err;

    int errors = 0;
    int checks = 0;

    register_window_file #(.WIDTH(32), .NWINDOWS(4)) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .RA       (ra),
        .RB       (rb),
        .Aout     (aout),
        .Bout     (bout),
        .RD       (rd),
        .in       (wdata),
        .WE       (we),
        .Save     (save),
        .Restore  (restore),
        .CWP_WE   (cwp_we),
        .CWP_in   (cwp_in),
        .WIM_WE   (wim_we),
        .WIM_in   (wim_in),
        .CWP      (cwp),
        .WIM      (wim),
        .Ovf_trap (ovf),
        .Unf_trap (unf),
        .Err      (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one clock cycle of control/write inputs, then returns them to idle.
    task automatic applyStimulus(input logic w, input logic [4:0] addr,
                                 input logic [31:0] data, input logic sv,
                                 input logic rs, input logic cw,
                                 input logic [1:0] cv, input logic ww,
                                 input logic [3:0] wv);
        we = w; rd = addr; wdata = data; save = sv; restore = rs;
        cwp_we = cw; cwp_in = cv; wim_we = ww; wim_in = wv;
        @(posedge clk);
        #1;
        we = 0; rd = 0; wdata = 0; save = 0; restore = 0;
        cwp_we = 0; cwp_in = 0; wim_we = 0; wim_in = 0;
    endtask

    task automatic readPorts(input logic [4:0] a, input logic [4:0] b);
        ra = a;
        rb = b;
        #1;
    endtask

    initial begin
        rst_n = 0; ra = 0; rb = 0;
        we = 0; rd = 0; wdata = 0; save = 0; restore = 0;
        cwp_we = 0; cwp_in = 0; wim_we = 0; wim_in = 0;

        // Reset state
        #2;
        readPorts(5, 16);
        checkOutput("rst_cwp", 32'(cwp), 32'h0);
        checkOutput("rst_wim", 32'(wim), 32'h0);
        checkOutput("rst_pulses", {29'h0, ovf, unf, err}, 32'h0);
        checkOutput("rst_r5", aout, 32'h0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Test 1: basic write/read, no bypass, r0 hardwired
        applyStimulus(1, 5, 32'h00001111, 0, 0, 0, 0, 0, 0);
        readPorts(5, 5);
        checkOutput("t1_r5_a", aout, 32'h00001111);
        checkOutput("t1_r5_b", bout, 32'h00001111);
        we = 1; rd = 5; wdata = 32'h00002222;
        #1;
        checkOutput("t1_nobypass", aout, 32'h00001111);
        @(posedge clk);
        #1;
        we = 0;
        checkOutput("t1_r5_new", aout, 32'h00002222);
        applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        readPorts(0, 0);
        checkOutput("t1_r0", aout, 32'h0);

        // Test 2: outs of window 0 appear as ins of window 3
        applyStimulus(1, 8, 32'hAAAA0000, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("t2_save_cwp", 32'(cwp), 32'h3);
        readPorts(24, 8);
        checkOutput("t2_r24_w3", aout, 32'hAAAA0000);
        checkOutput("t2_r8_w3", bout, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("t2_restore_cwp", 32'(cwp), 32'h0);
        readPorts(8, 24);
        checkOutput("t2_r8_w0", aout, 32'hAAAA0000);
        checkOutput("t2_r24_w0", bout, 32'h0);

        // Test 3: locals private; write alongside Save uses the old window
        applyStimulus(1, 16, 32'h00001234, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 9, 32'h0000CAFE, 1, 0, 0, 0, 0, 0);
        checkOutput("t3_cwp3", 32'(cwp), 32'h3);
        readPorts(25, 9);
        checkOutput("t3_r25_w3", aout, 32'h0000CAFE);
        checkOutput("t3_r9_w3", bout, 32'h0);
        applyStimulus(1, 16, 32'h00005678, 0, 0, 0, 0, 0, 0);
        readPorts(16, 16);
        checkOutput("t3_r16_w3", aout, 32'h00005678);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        readPorts(16, 9);
        checkOutput("t3_r16_w0", aout, 32'h00001234);
        checkOutput("t3_r9_w0", bout, 32'h0000CAFE);

        // Test 4: overflow/underflow traps
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'b1000);
        checkOutput("t4_wim", 32'(wim), 32'h8);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("t4_ovf", 32'(ovf), 32'h1);
        checkOutput("t4_ovf_cwp", 32'(cwp), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_ovf_clear", 32'(ovf), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'b0010);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("t4_unf", 32'(unf), 32'h1);
        checkOutput("t4_unf_ovf", 32'(ovf), 32'h0);
        checkOutput("t4_unf_cwp", 32'(cwp), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_unf_clear", 32'(unf), 32'h0);
        // Save checks old WIM (0010) while WIM loads 1000 on the same edge
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 4'b1000);
        checkOutput("t4_oldwim_cwp", 32'(cwp), 32'h3);
        checkOutput("t4_oldwim_ovf", 32'(ovf), 32'h0);
        checkOutput("t4_oldwim_wim", 32'(wim), 32'h8);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 4'b0000);
        checkOutput("t4_back_cwp", 32'(cwp), 32'h0);

        // Test 5: simultaneous Save/Restore, direct CWP load priority
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("t5_err", 32'(err), 32'h1);
        checkOutput("t5_err_cwp", 32'(cwp), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_err_clear", 32'(err), 32'h0);
        applyStimulus(0, 0, 0, 1, 0, 1, 2, 0, 0);
        checkOutput("t5_cwpwe_cwp", 32'(cwp), 32'h2);
        checkOutput("t5_cwpwe_traps", {29'h0, ovf, unf, err}, 32'h0);

        // Test 6: asynchronous reset mid-operation
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'b0101);
        applyStimulus(1, 16, 32'h0BADF00D, 0, 0, 0, 0, 0, 0);
        readPorts(16, 5);
        checkOutput("t6_pre_r16", aout, 32'h0BADF00D);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("t6_pre_err", 32'(err), 32'h1);
        we = 1; rd = 17; wdata = 32'h77777777;
        #1;
        rst_n = 0;
        #1;
        checkOutput("t6_cwp", 32'(cwp), 32'h0);
        checkOutput("t6_wim", 32'(wim), 32'h0);
        checkOutput("t6_pulses", {29'h0, ovf, unf, err}, 32'h0);
        readPorts(16, 5);
        checkOutput("t6_r16", aout, 32'h0);
        checkOutput("t6_r5", bout, 32'h0);
        we = 0; rd = 0; wdata = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        readPorts(17, 8);
        checkOutput("t6_lost_write", aout, 32'h0);
        checkOutput("t6_r8", bout, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
